xgbe_tx_shaper: RTL

XGBE_TX_SHAPER -- requirements
Module: xgbe_tx_shaper

---
 rtl/xgbe_tx_shaper.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/xgbe_tx_shaper.sv
// Router-to-MAC transmit shaper: passes frames through with no added latency,
// enforces an inter-frame gap, truncates over-long frames and keeps frame statistics.
module xgbe_tx_shaper #(
    parameter int DATA_WIDTH = 64,
    parameter int IFG_CYCLES = 1,
    parameter int MAX_BEATS  = 190,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    xgemac_clk_156,
    input  logic                    core_reset,
    input  logic                    enable,
    input  logic                    stats_clear,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    input  logic                    m_axis_tready,
    output logic [CNT_WIDTH-1:0]    tx_frame_cnt,
    output logic [CNT_WIDTH-1:0]    tx_trunc_cnt
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int GAP_W  = 4;
    localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(MAX_BEATS - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, FRAME, DROP, GAP} state_t;

    // With no gap configured, a frame end returns straight to IDLE.
    localparam state_t END_STATE = (IFG_CYCLES == 0) ? IDLE : GAP;

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic              pass_through;
    logic              at_limit;
    logic              xfer;
    logic [1:0]        cnt_inc;

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;

    always_comb begin
        pass_through  = !core_reset && ((state_reg == IDLE && enable) || state_reg == FRAME);
        at_limit      = (state_reg == FRAME) && (beat_cnt_reg == BEAT_LAST) && !s_axis_tlast;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        if (pass_through) begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast || at_limit;
            m_axis_tuser  = at_limit;
        end else if (!core_reset && state_reg == DROP) begin
            s_axis_tready = 1'b1;
        end
        xfer = pass_through && s_axis_tvalid && m_axis_tready;
    end

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        cnt_inc       = 2'b00;
        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    beat_cnt_next = BEAT_W'(1);
                    if (s_axis_tlast) begin
                        state_next = END_STATE;
                        cnt_inc[0] = 1'b1;
                    end else begin
                        state_next = FRAME;
                    end
                end
            end
            FRAME: begin
                if (xfer) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (s_axis_tlast) begin
                        state_next = END_STATE;
                        cnt_inc[0] = 1'b1;
                    end else if (at_limit) begin
                        state_next = DROP;
                        cnt_inc    = 2'b11;
                    end
                end
            end
            DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_next = END_STATE;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Every entry into GAP starts a fresh idle count.
        if (state_next == GAP && state_reg != GAP) begin
            gap_cnt_next = '0;
        end
    end

    always_ff @(posedge xgemac_clk_156) begin
        if (core_reset) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
        end
    end

    // Index 0 counts completed frames, index 1 truncated frames; both saturate.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            logic [CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge xgemac_clk_156) begin
                if (core_reset || stats_clear) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign tx_frame_cnt = g_stat[0].cnt_reg;
    assign tx_trunc_cnt = g_stat[1].cnt_reg;

endmodule
